// File: rtl/vape_exec_monitor_pkg.sv
// Shared encodings for the VAPE execution monitor: FSM states,
// register offsets and the bit position of each sub-check in CAUSE.
package vape_exec_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } mon_state_e;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CAUSE  = 2'd1;
    localparam logic [1:0] REG_VCOUNT = 2'd2;
    localparam logic [1:0] REG_RUNLEN = 2'd3;

    localparam int CAUSE_IMMUT  = 0;
    localparam int CAUSE_ATOMIC = 1;
    localparam int CAUSE_RESET  = 2;
    localparam int CAUSE_OUTPUT = 3;

    localparam logic [15:0] RUNLEN_MAX = 16'hFFFF;
    localparam logic [7:0]  VCOUNT_MAX = 8'hFF;

endpackage

// File: rtl/vape_mon_regs.sv
// Peripheral slot of the execution monitor: address decode, read mux
// and the STATUS-write clear request (gating by FSM state is done by the caller).
module vape_mon_regs
    import vape_exec_monitor_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR = 14'h00C8
) (
    input  logic [13:0] per_addr,
    input  logic        per_din0,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [1:0]  state,
    input  logic        exec,
    input  logic        exec_ok,
    input  logic [3:0]  cause,
    input  logic [7:0]  vcount,
    input  logic [15:0] runlen,
    output logic [15:0] per_dout,
    output logic        clr_req
);

    logic [13:0] offs;
    logic        hit;
    logic [1:0]  reg_sel;

    always_comb begin
        offs     = per_addr - BASE_ADDR;
        hit      = per_en && (offs < 14'd4);
        reg_sel  = offs[1:0];
        per_dout = 16'h0000;
        clr_req  = 1'b0;

        if (hit && (per_we == 2'b00)) begin
            case (reg_sel)
                REG_STATUS: per_dout = {12'b0, exec, exec_ok, state};
                REG_CAUSE:  per_dout = {12'b0, cause};
                REG_VCOUNT: per_dout = {8'b0, vcount};
                REG_RUNLEN: per_dout = runlen;
                default:    per_dout = 16'h0000;
            endcase
        end

        if (hit && (per_we != 2'b00) && (reg_sel == REG_STATUS)) begin
            clr_req = per_din0;
        end
    end

endmodule

// File: rtl/vape_exec_monitor.sv
// Tracks one execution of the region [ER_min, ER_max], latches the first
// failing VAPE sub-check, counts violations and exposes status registers.
module vape_exec_monitor
    import vape_exec_monitor_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR = 14'h00C8
) (
    input  logic        clk,
    input  logic        puc,
    input  logic [15:0] pc,
    input  logic [15:0] ER_min,
    input  logic [15:0] ER_max,
    input  logic        exec,
    input  logic        exec1,
    input  logic        exec2,
    input  logic        exec3,
    input  logic        exec4,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        exec_ok
);

    mon_state_e  state_q, state_d;
    logic [15:0] pc_prev_q, pc_prev_d;
    logic [3:0]  cause_q, cause_d;
    logic [7:0]  vcount_q, vcount_d;
    logic [15:0] runlen_q, runlen_d;
    logic        exec_ok_q, exec_ok_d;

    logic        in_er;
    logic        fall;
    logic        entry;
    logic        exit_er;
    logic        clr_req;
    logic        clr;
    logic [3:0]  ok_vec;
    logic        unused_din;

    assign unused_din = ^per_din[15:1];

    always_comb begin
        ok_vec               = 4'h0;
        ok_vec[CAUSE_IMMUT]  = exec1;
        ok_vec[CAUSE_ATOMIC] = exec2;
        ok_vec[CAUSE_RESET]  = exec3;
        ok_vec[CAUSE_OUTPUT] = exec4;

        in_er   = (pc >= ER_min) && (pc <= ER_max);
        fall    = !exec && (state_q != ST_FAIL);
        entry   = exec && (pc == ER_min) && (state_q != ST_RUN);
        exit_er = (state_q == ST_RUN) && (pc_prev_q == ER_max) && !in_er;
        clr     = clr_req && (state_q != ST_RUN);

        state_d = state_q;
        if (fall) begin
            state_d = ST_FAIL;
        end else if (entry) begin
            state_d = ST_RUN;
        end else if (exit_er) begin
            state_d = ST_DONE;
        end

        pc_prev_d = pc;
        exec_ok_d = (state_d == ST_DONE);

        // Only cycles actually spent inside the region are counted, so the
        // exit cycle (pc already outside) does not inflate the run length.
        runlen_d = runlen_q;
        if (entry) begin
            runlen_d = 16'd1;
        end else if ((state_q == ST_RUN) && in_er && !fall && (runlen_q != RUNLEN_MAX)) begin
            runlen_d = runlen_q + 16'd1;
        end

        // A clear in the same cycle as a fall is overridden by the fall,
        // which then behaves as the first event after a clean slate.
        cause_d  = clr ? 4'h0 : cause_q;
        vcount_d = clr ? 8'h00 : vcount_q;
        if (fall) begin
            if (clr || (cause_q == 4'h0)) begin
                cause_d = ~ok_vec;
            end
            if (clr) begin
                vcount_d = 8'd1;
            end else if (vcount_q != VCOUNT_MAX) begin
                vcount_d = vcount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (puc) begin
            state_q   <= ST_IDLE;
            pc_prev_q <= 16'h0000;
            cause_q   <= 4'h0;
            vcount_q  <= 8'h00;
            runlen_q  <= 16'h0000;
            exec_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_prev_q <= pc_prev_d;
            cause_q   <= cause_d;
            vcount_q  <= vcount_d;
            runlen_q  <= runlen_d;
            exec_ok_q <= exec_ok_d;
        end
    end

    assign exec_ok = exec_ok_q;

    vape_mon_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .per_addr (per_addr),
        .per_din0 (per_din[0]),
        .per_en   (per_en),
        .per_we   (per_we),
        .state    (state_q),
        .exec     (exec),
        .exec_ok  (exec_ok_q),
        .cause    (cause_q),
        .vcount   (vcount_q),
        .runlen   (runlen_q),
        .per_dout (per_dout),
        .clr_req  (clr_req)
    );

endmodule
